// File: rtl/pipe_unpack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_unpack: DATA_W word -> LANE_W lane width-down converter (valid/ready)  |
// | Option: PIPE_UNPACK_MSB_FIRST_EN emits the MSB lane first.   Rev 1.0        |
// +----------------------------------------------------------------------------+
module pipe_unpack #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              valid_i,
  input  logic [DATA_W-1:0]                 data_i,
  input  logic [$clog2(DATA_W/LANE_W)-1:0]  nlanes_i,
  output logic                              ready_o,
  output logic                              valid_o,
  output logic [LANE_W-1:0]                 data_o,
  output logic                              last_o,
  input  logic                              ready_i
);

  localparam int N    = DATA_W / LANE_W;
  localparam int NL_W = $clog2(N);

  localparam logic [NL_W:0]   C_ONE      = (NL_W+1)'(1);
  localparam logic [NL_W:0]   C_FULL_CNT = (NL_W+1)'(N);
  localparam logic [NL_W-1:0] C_TOP_IDX  = NL_W'(N - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [NL_W-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [NL_W:0]       cnt_q, cnt_d;

  logic [NL_W:0]       eff_cnt;
  logic [NL_W-1:0]     lane_sel;
  logic                is_last;
  logic                load;

  // A zero lane count encodes a full word.
  assign eff_cnt = (nlanes_i == '0) ? C_FULL_CNT : {1'b0, nlanes_i};

`ifdef PIPE_UNPACK_MSB_FIRST_EN
  assign lane_sel = C_TOP_IDX - idx_q;
`else
  assign lane_sel = idx_q;
`endif

  assign is_last = (state_q == SHIFT) && ({1'b0, idx_q} == (cnt_q - C_ONE));
  assign ready_o = !rst_n && ((state_q == IDLE) || (is_last && ready_i));
  assign load    = valid_i && ready_o;
  assign valid_o = (state_q == SHIFT);
  assign last_o  = is_last;
  assign data_o  = (state_q == SHIFT) ? word_q[lane_sel*LANE_W +: LANE_W] : '0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = SHIFT;
      idx_d   = '0;
      word_d  = data_i;
      cnt_d   = eff_cnt;
    end else if ((state_q == SHIFT) && ready_i) begin
      if (is_last) begin
        state_d = IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_unpack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_unpack: scoreboard bench for pipe_unpack (both lane orders)         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_pipe_unpack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [1:0]  nlanes_i = '0;
  logic        ready_o;
  logic        valid_o;
  logic [7:0]  data_o;
  logic        last_o;
  logic        ready_i = 1'b1;

  int errs   = 0;
  int checks = 0;
  int pops   = 0;
  logic [8:0] sb_q[$];

  pipe_unpack #(.DATA_W(32), .LANE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i),
    .nlanes_i(nlanes_i), .ready_o(ready_o), .valid_o(valid_o),
    .data_o(data_o), .last_o(last_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected lane k of a word with count c, in the build's lane order.
  function automatic logic [7:0] exp_lane(input logic [31:0] d, input int k);
    int idx;
`ifdef PIPE_UNPACK_MSB_FIRST_EN
    idx = 3 - k;
`else
    idx = k;
`endif
    return d[idx*8 +: 8];
  endfunction

  task automatic push_word(input logic [31:0] d, input logic [1:0] nl);
    int c;
    c = (nl == 2'd0) ? 4 : int'(nl);
    for (int k = 0; k < c; k++)
      sb_q.push_back({(k == c - 1), exp_lane(d, k)});
  endtask

  // Drive a word and return one #1 after its accept edge.
  task automatic send(input logic [31:0] d, input logic [1:0] nl, input bit keep_valid);
    bit acc;
    acc = 0;
    valid_i = 1'b1; data_i = d; nlanes_i = nl;
    push_word(d, nl);
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      if (ready_o) acc = 1;
      @(posedge clk); #1;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    if (!keep_valid) valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !valid_o) done = 1;
    end
    chk({name, "_idle_reached"}, {31'd0, done}, 32'd1);
    chk({name, "_idle_ready_o"}, {31'd0, ready_o}, 32'd1);
  endtask

  // Monitor: every lane handshake pops and compares one scoreboard entry.
  always @(negedge clk) begin
    if (!rst_n && valid_o && ready_i) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_lane", {23'd0, last_o, data_o}, 32'h1FF);
      end else begin
        chk("lane", {23'd0, last_o, data_o}, {23'd0, sb_q.pop_front()});
      end
      pops++;
    end
  end

  initial begin
    logic [6:0] bp_pat;
    logic [7:0] prev_data;
    logic       prev_last;
    logic       prev_rdy;
    int         base;

    // Reset state
    #3;
    chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("rst_ready_o", {31'd0, ready_o}, 32'd0);
    chk("rst_data_o", {24'd0, data_o}, 32'd0);
    chk("rst_last_o", {31'd0, last_o}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("idle_ready_o", {31'd0, ready_o}, 32'd1);

    // Single full word
    send(32'hA5B6C7D8, 2'd0, 0);
    @(negedge clk);
`ifdef PIPE_UNPACK_MSB_FIRST_EN
    chk("first_lane_msb", {24'd0, data_o}, 32'h000000A5);
`else
    chk("first_lane_lsb", {24'd0, data_o}, 32'h000000D8);
`endif
    chk("first_lane_valid", {31'd0, valid_o}, 32'd1);
    wait_idle("single");

    // Back-to-back words, no gap, ready_o only on last lanes
    @(posedge clk); #1;
    send(32'h03020100, 2'd0, 1);
    valid_i = 1'b1; data_i = 32'h07060504; nlanes_i = 2'd0;
    push_word(32'h07060504, 2'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b_valid_o", {31'd0, valid_o}, 32'd1);
      chk("b2b_last_o", {31'd0, last_o}, {31'd0, (i == 3 || i == 7)});
      chk("b2b_ready_o", {31'd0, ready_o}, {31'd0, (i == 3 || i == 7)});
      @(posedge clk); #1;
      if (i == 3) valid_i = 1'b0;
    end
    @(negedge clk);
    chk("b2b_after_valid_o", {31'd0, valid_o}, 32'd0);
    chk("b2b_after_ready_o", {31'd0, ready_o}, 32'd1);

    // Partial words
    @(posedge clk); #1;
    send(32'h11223344, 2'd2, 0);
    send(32'hDEADBEEF, 2'd1, 0);
    @(negedge clk);
    chk("single_lane_last", {31'd0, last_o}, 32'd1);
    wait_idle("partial");

    // Backpressure
    @(posedge clk); #1;
    send(32'h12345678, 2'd0, 0);
    bp_pat = 7'b1101001;
    prev_rdy = 1'b1; prev_data = '0; prev_last = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ready_i = bp_pat[i];
      @(negedge clk);
      chk("bp_ready_o", {31'd0, ready_o}, {31'd0, (i == 6)});
      if (!prev_rdy) begin
        chk("bp_hold_data", {24'd0, data_o}, {24'd0, prev_data});
        chk("bp_hold_last", {31'd0, last_o}, {31'd0, prev_last});
      end
      prev_rdy = ready_i; prev_data = data_o; prev_last = last_o;
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    wait_idle("bp");

    // Asynchronous reset in the middle of a word
    @(posedge clk); #1;
    base = pops;
    send(32'hCAFEF00D, 2'd0, 0);
    for (int t = 0; t < 20 && pops < base + 2; t++) begin
      @(posedge clk); #1;
    end
    chk("mid_pops", pops - base, 32'd2);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("mid_rst_data_o", {24'd0, data_o}, 32'd0);
    chk("mid_rst_last_o", {31'd0, last_o}, 32'd0);
    chk("mid_rst_ready_o", {31'd0, ready_o}, 32'd0);
    sb_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    send(32'h0000BEEF, 2'd0, 0);
    wait_idle("post_rst");

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_unpack.md
Name: pipe_unpack

Overview:
Downstream width-down converter for the 32-bit valid/ready block pipe. It accepts one DATA_W word per input handshake and emits it as a sequence of LANE_W lanes on a valid/ready output, with a per-word lane count and a last-lane marker. It sits directly after the block pipe output and feeds byte-oriented consumers (serializers, FIFOs), sustaining full throughput with no bubble between words.

Parameters:
DATA_W, 32, input word width; must equal LANE_W*N, with N a power of two and N >= 2
LANE_W, 8, output lane width
N (localparam), DATA_W/LANE_W, lanes per word (4 by default)
NL_W (localparam), $clog2(N), width of the lane-count field (2 by default)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-high (block is in reset while rst_n=1)
valid_i  input  1  upstream word valid
data_i  input  DATA_W  upstream word
nlanes_i  input  NL_W  lanes to emit from this word; 0 encodes N (all lanes)
ready_o  output  1  block accepts a word this cycle
valid_o  output  1  output lane valid
data_o  output  LANE_W  output lane
last_o  output  1  current lane is the final lane of its word
ready_i  input  1  downstream ready

Behaviour:
- Reset (async, rst_n=1): state=IDLE, lane index=0, holding register=0, stored count=0; valid_o=0, data_o=0, last_o=0; ready_o forced 0 while rst_n=1.
- Accept on valid_i&ready_o at a rising clk: latch data_i and the effective count (nlanes_i==0 -> N); set index=0; go to SHIFT.
- States:
  - IDLE: valid_o=0; ready_o=1.
  - SHIFT: valid_o=1; data_o=lane[index]; last_o=(index==count-1).
- Transitions:
  - Lane handshake (valid_o&ready_i) with last_o=0: index+1.
  - Lane handshake with last_o=1 and valid_i=1: load the new word in the same cycle, index=0, stay in SHIFT (no bubble).
  - Lane handshake with last_o=1 and valid_i=0: go to IDLE.
- ready_o = IDLE | (SHIFT & last_o & ready_i). This is combinational from ready_i; there is no combinational path from valid_i to valid_o.
- Lane order: lane k = data[k*LANE_W +: LANE_W]; LSB lane first by default.
- Latency: first lane appears on valid_o the cycle after the accept edge. A word with count c takes c lane cycles. Steady state runs at 1 lane/cycle with ready_i=1; N-lane words give 1 word per N cycles.
- Backpressure: while ready_i=0, data_o, last_o, valid_o and index hold stable. Unused lanes (index>=count) are never emitted.
- Single-lane word (count=1): last_o=1 on the first and only lane.
- nlanes_i is sampled only on an accept edge; changes at other times have no effect.
- Reset mid-word: the partial word is discarded and outputs return to reset values immediately (asynchronously).

Optional Feature:
PIPE_UNPACK_MSB_FIRST_EN
- Defined: lane order is reversed. Lane k is emitted from data[(N-1-k)*LANE_W +: LANE_W], so the MSB lane goes first. With count c<N, the top c lanes are emitted, MSB first.
- Undefined: LSB-first order as above.
- Handshake, count and last_o timing are identical in both builds.

Test Plan:
- Single word 32'hA5B6C7D8, nlanes_i=0, ready_i=1 -> data_o D8,C7,B6,A5 on 4 consecutive cycles starting 1 cycle after accept; last_o only on A5; then valid_o=0, ready_o=1.
- Back-to-back words 32'h03020100 and 32'h07060504, valid_i held high, ready_i=1 -> 8 lanes 00..07 with no gap; ready_o pulses exactly on the cycles last_o=1 (lanes 03 and 07).
- Partial word 32'h11223344, nlanes_i=2 -> lanes 44,33 with last_o on 33; then nlanes_i=1 with 32'hDEADBEEF -> single lane EF with last_o=1.
- Backpressure: word 32'h12345678, ready_i toggling 1,0,0,1,0,1,1 -> lanes 78,56,34,12 emitted in order; data_o/last_o held while ready_i=0; ready_o=0 until the lane 12 handshake.
- Reset mid-word: assert rst_n=1 asynchronously after lane 2 of 32'hCAFEF00D -> valid_o, data_o, last_o go 0 immediately; after release the next word 32'h0000BEEF emits EF,BE,00,00 fresh.
- With PIPE_UNPACK_MSB_FIRST_EN defined: 32'hA5B6C7D8, nlanes_i=0 -> lanes A5,B6,C7,D8 with last_o on D8.
